store_w_align: RTL and testbench

- Next-generation W-channel generator for the vector store path. It sits between the sequential-store byte stream and the AXI W channel.
- Accepts a queue of store-transaction descriptors, each giving a start offset and a byte count. It realigns the packed byte stream to the bus offset of each transaction.
- It merges mask-unit byte enables into wstrb and emits AXI W beats with correct wlast, including the extra flush beat that an unaligned tail requires.
- Generalises the previous store datapath in bus width, number of outstanding transactions, and unaligned/masked support.

---
 rtl/store_w_align_if.sv | 41 ++++
 rtl/store_w_align.sv | 166 ++++++++++++++++
 tb/tb_store_w_align.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/store_w_align_if.sv
`default_nettype none
// ============================================================================
//  Module  : store_w_align_if
//  Brief   : Descriptor, packed-stream and AXI W bundle for store_w_align.
//  Rev     : 1.0  initial release
// ============================================================================
interface store_w_align_if #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int LEN_WIDTH      = 12
);
    localparam int c_nb = AXI_DATA_WIDTH / 8;
    localparam int c_ow = $clog2(c_nb);

    logic                      txn_valid_i;
    logic                      txn_ready_o;
    logic [c_ow-1:0]           txn_off_i;
    logic [LEN_WIDTH-1:0]      txn_nbytes_m1_i;
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [AXI_DATA_WIDTH-1:0] in_data_i;
    logic [c_nb-1:0]           in_mask_i;
    logic                      w_valid_o;
    logic                      w_ready_i;
    logic [AXI_DATA_WIDTH-1:0] w_data_o;
    logic [c_nb-1:0]           w_strb_o;
    logic                      w_last_o;
    logic                      idle_o;

    modport slave (
        input  txn_valid_i, txn_off_i, txn_nbytes_m1_i,
        input  in_valid_i, in_data_i, in_mask_i, w_ready_i,
        output txn_ready_o, in_ready_o, w_valid_o, w_data_o, w_strb_o, w_last_o, idle_o
    );

    modport master (
        output txn_valid_i, txn_off_i, txn_nbytes_m1_i,
        output in_valid_i, in_data_i, in_mask_i, w_ready_i,
        input  txn_ready_o, in_ready_o, w_valid_o, w_data_o, w_strb_o, w_last_o, idle_o
    );
endinterface
`default_nettype wire

// File: rtl/store_w_align.sv
`default_nettype none
// ============================================================================
//  Module  : store_w_align
//  Brief   : Realigns a packed store byte stream to per-transaction bus offsets
//            and emits AXI W beats with merged mask strobes and wlast.
//  Rev     : 1.0  initial release
// ============================================================================
module store_w_align #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int TXN_DEPTH      = 4,
    parameter int LEN_WIDTH      = 12
) (
    input logic            clk_i,
    input logic            rst_i,
    store_w_align_if.slave bus
);
    localparam int c_nb = AXI_DATA_WIDTH / 8;
    localparam int c_ow = $clog2(c_nb);
    localparam int c_kw = LEN_WIDTH - c_ow + 1;
    localparam int c_pw = $clog2(TXN_DEPTH);
    localparam int c_cw = c_pw + 1;

    logic [c_ow-1:0]      fifo_off_q [TXN_DEPTH];
    logic [LEN_WIDTH-1:0] fifo_len_q [TXN_DEPTH];
    logic [c_pw-1:0]      wr_ptr_q, rd_ptr_q;
    logic [c_cw-1:0]      count_q, count_d;

    logic                 act_q;
    logic [c_ow-1:0]      off_q, lim_q;
    logic [c_kw-1:0]      k_q, nin_q, nout_q;

    logic [AXI_DATA_WIDTH-1:0] res_data_q;
    logic [c_nb-1:0]           res_vld_q;

    logic                      out_valid_q, out_last_q;
    logic [AXI_DATA_WIDTH-1:0] out_data_q;
    logic [c_nb-1:0]           out_strb_q;

    logic                        w_full, w_push, w_can, w_data_beat, w_last_in;
    logic                        w_load, w_retire, w_load_act;
    logic [c_kw-1:0]             w_k_inc, w_sel_nin, w_sel_nout;
    logic [c_pw-1:0]             w_sel_idx;
    logic [c_ow-1:0]             w_sel_off;
    logic [LEN_WIDTH-1:0]        w_sel_len;
    logic [LEN_WIDTH:0]          w_sel_sum;
    logic [c_nb-1:0]             w_cur_vld, w_al_vld;
    logic [c_ow:0]               w_shamt;
    logic [2*AXI_DATA_WIDTH-1:0] w_cat_data;
    logic [2*c_nb-1:0]           w_cat_vld;
    logic [AXI_DATA_WIDTH-1:0]   w_al_data, w_out_data;

    assign w_full      = (count_q == c_cw'(TXN_DEPTH));
    assign w_push      = bus.txn_valid_i && !w_full;
    assign w_can       = !out_valid_q || bus.w_ready_i;
    assign w_data_beat = (k_q < nin_q);
    assign w_last_in   = (k_q == nin_q - c_kw'(1));
    assign w_k_inc     = k_q + c_kw'(1);
    assign w_load      = w_can && act_q && (!w_data_beat || bus.in_valid_i);
    assign w_retire    = w_load && (w_k_inc == nout_q);

    // While retiring, the head is the finishing descriptor, so the successor sits one slot further.
    assign w_load_act  = (!act_q && (count_q != '0)) || (w_retire && (count_q > c_cw'(1)));
    assign w_sel_idx   = act_q ? (rd_ptr_q + c_pw'(1)) : rd_ptr_q;
    assign w_sel_off   = fifo_off_q[w_sel_idx];
    assign w_sel_len   = fifo_len_q[w_sel_idx];
    assign w_sel_sum   = {1'b0, w_sel_len} + (LEN_WIDTH+1)'(w_sel_off);
    assign w_sel_nin   = c_kw'(w_sel_len >> c_ow) + c_kw'(1);
    assign w_sel_nout  = c_kw'(w_sel_sum >> c_ow) + c_kw'(1);

    always_comb begin
        count_d = count_q;
        if (w_push && !w_retire) begin
            count_d = count_q + c_cw'(1);
        end else if (!w_push && w_retire) begin
            count_d = count_q - c_cw'(1);
        end
    end

    // Output byte j is byte (B - off + j) of {current beat, previous beat}.
    assign w_shamt    = (c_ow+1)'(c_nb) - {1'b0, off_q};
    assign w_cat_data = {bus.in_data_i, res_data_q};
    assign w_cat_vld  = {w_cur_vld, res_vld_q};
    assign w_al_data  = AXI_DATA_WIDTH'(w_cat_data >> {w_shamt, 3'b000});
    assign w_al_vld   = c_nb'(w_cat_vld >> w_shamt);

    for (genvar gi = 0; gi < c_nb; gi++) begin : g_byte
        assign w_cur_vld[gi] = w_data_beat && bus.in_mask_i[gi] &&
                               (!w_last_in || (c_ow'(gi) <= lim_q));
        assign w_out_data[8*gi +: 8] = w_al_vld[gi] ? w_al_data[8*gi +: 8] : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_off_q[wr_ptr_q] <= bus.txn_off_i;
            fifo_len_q[wr_ptr_q] <= bus.txn_nbytes_m1_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            act_q       <= 1'b0;
            off_q       <= '0;
            lim_q       <= '0;
            k_q         <= '0;
            nin_q       <= '0;
            nout_q      <= '0;
            res_data_q  <= '0;
            res_vld_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_pw'(1);
            end
            if (w_retire) begin
                rd_ptr_q <= rd_ptr_q + c_pw'(1);
            end

            if (w_load_act) begin
                act_q  <= 1'b1;
                off_q  <= w_sel_off;
                lim_q  <= w_sel_len[c_ow-1:0];
                k_q    <= '0;
                nin_q  <= w_sel_nin;
                nout_q <= w_sel_nout;
            end else if (w_retire) begin
                act_q  <= 1'b0;
            end else if (w_load) begin
                k_q    <= w_k_inc;
            end

            if (w_load_act) begin
                res_data_q <= '0;
                res_vld_q  <= '0;
            end else if (w_load) begin
                res_data_q <= bus.in_data_i;
                res_vld_q  <= w_cur_vld;
            end

            if (w_load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_out_data;
                out_strb_q  <= w_al_vld;
                out_last_q  <= (w_k_inc == nout_q);
            end else if (bus.w_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.txn_ready_o = !w_full;
    assign bus.in_ready_o  = act_q && w_data_beat && w_can;
    assign bus.w_valid_o   = out_valid_q;
    assign bus.w_data_o    = out_data_q;
    assign bus.w_strb_o    = out_strb_q;
    assign bus.w_last_o    = out_last_q;
    assign bus.idle_o      = (count_q == '0) && !act_q && !out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_store_w_align.sv
`default_nettype none
// ============================================================================
//  Module  : tb_store_w_align
//  Brief   : Directed self-checking bench for store_w_align (128-bit, depth 4).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_store_w_align;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;
    int   wb_cnt  = 0;
    int   hs0, wb0;

    store_w_align_if #(.AXI_DATA_WIDTH(128), .LEN_WIDTH(12)) bus ();

    store_w_align #(
        .AXI_DATA_WIDTH(128),
        .TXN_DEPTH     (4),
        .LEN_WIDTH     (12)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.in_valid_i && bus.in_ready_o) hs_cnt <= hs_cnt + 1;
        if (bus.w_valid_o && bus.w_ready_i)   wb_cnt <= wb_cnt + 1;
    end

    function automatic logic [127:0] seq(input logic [7:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b + 8'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [127:0] d, input logic [15:0] s,
                            input logic l);
        chk({tag, "_valid"}, bus.w_valid_o, 1'b1);
        chk({tag, "_data"},  bus.w_data_o, d);
        chk({tag, "_strb"},  bus.w_strb_o, s);
        chk({tag, "_last"},  bus.w_last_o, l);
    endtask

    task automatic push(input logic [3:0] off, input logic [11:0] nb);
        bus.txn_valid_i     = 1'b1;
        bus.txn_off_i       = off;
        bus.txn_nbytes_m1_i = nb;
        @(posedge clk); #1;
        bus.txn_valid_i     = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [127:0] d, input logic [15:0] m);
        int n;
        n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_mask_i  = m;
        #1;
        while (!bus.in_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_in_ready"}, bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.txn_valid_i     = 1'b0;
        bus.txn_off_i       = '0;
        bus.txn_nbytes_m1_i = '0;
        bus.in_valid_i      = 1'b0;
        bus.in_data_i       = '0;
        bus.in_mask_i       = '0;
        bus.w_ready_i       = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_w_valid",   bus.w_valid_o, 1'b0);
        chk("rst_w_data",    bus.w_data_o, 128'h0);
        chk("rst_w_strb",    bus.w_strb_o, 16'h0);
        chk("rst_w_last",    bus.w_last_o, 1'b0);
        chk("rst_txn_ready", bus.txn_ready_o, 1'b1);
        chk("rst_in_ready",  bus.in_ready_o, 1'b0);
        chk("rst_idle",      bus.idle_o, 1'b1);
        rst = 1'b0;

        // Aligned two-beat transaction
        push(4'd0, 12'd31);
        chk("t1_idle_busy", bus.idle_o, 1'b0);
        send_beat("t1_b0", seq(8'h10), 16'hFFFF);
        chk_beat("t1_b0", seq(8'h10), 16'hFFFF, 1'b0);
        send_beat("t1_b1", seq(8'h20), 16'hFFFF);
        chk_beat("t1_b1", seq(8'h20), 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        chk("t1_drain_valid", bus.w_valid_o, 1'b0);
        chk("t1_idle", bus.idle_o, 1'b1);

        // Unaligned spill into a flush beat
        hs0 = hs_cnt;
        push(4'd4, 12'd15);
        send_beat("t2_b0", seq(8'h00), 16'hFFFF);
        chk_beat("t2_b0", seq(8'h00) << 32, 16'hFFF0, 1'b0);
        chk("t2_flush_in_ready", bus.in_ready_o, 1'b0);
        @(posedge clk); #1;
        chk_beat("t2_b1", 128'h0F0E0D0C, 16'h000F, 1'b1);
        chk("t2_handshakes", 128'(hs_cnt - hs0), 128'd1);
        @(posedge clk); #1;
        chk("t2_idle", bus.idle_o, 1'b1);

        // Partial tail merged with mask
        push(4'd0, 12'd9);
        send_beat("t3_b0", seq(8'h40), 16'hFF0F);
        chk_beat("t3_b0", 128'h0000_0000_0000_4948_0000_0000_4342_4140, 16'h030F, 1'b1);
        @(posedge clk); #1;
        chk("t3_idle", bus.idle_o, 1'b1);

        // Backpressure mid-burst
        hs0 = hs_cnt;
        wb0 = wb_cnt;
        push(4'd0, 12'd47);
        send_beat("t4_b0", seq(8'h50), 16'hFFFF);
        chk_beat("t4_b0", seq(8'h50), 16'hFFFF, 1'b0);
        bus.w_ready_i  = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = seq(8'h60);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_hold_in_ready", bus.in_ready_o, 1'b0);
            @(posedge clk); #1;
            chk_beat("t4_hold", seq(8'h50), 16'hFFFF, 1'b0);
        end
        bus.w_ready_i = 1'b1;
        #1;
        chk("t4_release_in_ready", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk_beat("t4_b1", seq(8'h60), 16'hFFFF, 1'b0);
        send_beat("t4_b2", seq(8'h70), 16'hFFFF);
        chk_beat("t4_b2", seq(8'h70), 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        chk("t4_handshakes", 128'(hs_cnt - hs0), 128'd3);
        chk("t4_w_beats", 128'(wb_cnt - wb0), 128'd3);

        // Queue full, rejected push on simultaneous pop, back-to-back beats
        push(4'd0, 12'd15);
        push(4'd0, 12'd15);
        push(4'd0, 12'd15);
        push(4'd0, 12'd15);
        chk("t5_full", bus.txn_ready_o, 1'b0);
        bus.txn_valid_i     = 1'b1;
        bus.txn_off_i       = 4'd8;
        bus.txn_nbytes_m1_i = 12'd3;
        bus.in_valid_i      = 1'b1;
        bus.in_mask_i       = 16'hFFFF;
        bus.in_data_i       = seq(8'h80);
        #1;
        chk("t5_in_ready0", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.txn_valid_i = 1'b0;
        chk_beat("t5_b0", seq(8'h80), 16'hFFFF, 1'b1);
        chk("t5_ready_rise", bus.txn_ready_o, 1'b1);
        bus.in_data_i = seq(8'h90);
        #1;
        chk("t5_in_ready1", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        chk_beat("t5_b1", seq(8'h90), 16'hFFFF, 1'b1);
        bus.in_data_i = seq(8'hA0);
        @(posedge clk); #1;
        chk_beat("t5_b2", seq(8'hA0), 16'hFFFF, 1'b1);
        bus.in_data_i = seq(8'hB0);
        @(posedge clk); #1;
        chk_beat("t5_b3", seq(8'hB0), 16'hFFFF, 1'b1);
        bus.in_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle", bus.idle_o, 1'b1);

        // Reset during beat 1 of a three-beat transaction
        push(4'd0, 12'd47);
        send_beat("t6_b0", seq(8'h11), 16'hFFFF);
        send_beat("t6_b1", seq(8'h21), 16'hFFFF);
        chk_beat("t6_b1", seq(8'h21), 16'hFFFF, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_w_valid",   bus.w_valid_o, 1'b0);
        chk("t6_rst_w_data",    bus.w_data_o, 128'h0);
        chk("t6_rst_w_strb",    bus.w_strb_o, 16'h0);
        chk("t6_rst_w_last",    bus.w_last_o, 1'b0);
        chk("t6_rst_idle",      bus.idle_o, 1'b1);
        chk("t6_rst_txn_ready", bus.txn_ready_o, 1'b1);
        chk("t6_rst_in_ready",  bus.in_ready_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(4'd4, 12'd3);
        send_beat("t6_fresh", seq(8'h33), 16'hFFFF);
        chk_beat("t6_fresh", 128'h0000_0000_0000_0000_3635_3433_0000_0000, 16'h00F0, 1'b1);
        @(posedge clk); #1;
        chk("t6_idle", bus.idle_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
